// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
// Sequences the pixel-clock PLL reset, qualifies a stable lock, and only then
// releases the downstream video reset. Failed attempts are retried, and a fault
// is latched after MAX_RETRIES consecutive timeouts. A lock loss while running
// restarts the whole sequence. Runs entirely on the free-running board clock.
module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES      = 27,
  parameter int LOCK_TIMEOUT_CYCLES = 270000,
  parameter int LOCK_STABLE_CYCLES  = 2700,
  parameter int MAX_RETRIES         = 3,
  parameter int SYNC_STAGES         = 2
) (
  input  logic                               in_clk,
  input  logic                               rst,
  input  logic                               pll_lock,
  input  logic                               restart,
  output logic                               pll_reset,
  output logic                               sys_rst,
  output logic                               clk_ready,
  output logic                               lock_fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
  output logic [7:0]                         loss_cnt,
  output logic [2:0]                         state_o
);

  localparam int RC_W    = $clog2(MAX_RETRIES + 1);
  // The shared cycle counter must reach the largest per-state bound minus one.
  localparam int CNT_M1  = (LOCK_TIMEOUT_CYCLES > LOCK_STABLE_CYCLES) ?
                           LOCK_TIMEOUT_CYCLES : LOCK_STABLE_CYCLES;
  localparam int CNT_MAX = (CNT_M1 > PLL_RST_CYCLES) ? CNT_M1 : PLL_RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [RC_W-1:0]    retry_n;
  logic [7:0]         loss_n;
  logic [SYNC_STAGES-1:0] sync_pipe;
  logic               lock_s;

  // Bring the asynchronous PLL lock into the board-clock domain.
  always_ff @(posedge in_clk) begin
    if (rst) sync_pipe <= '0;
    else     sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], pll_lock};
  end

  assign lock_s = sync_pipe[SYNC_STAGES-1];

  // State register plus the counters that ride along with it.
  always_ff @(posedge in_clk) begin
    if (rst) begin
      state     <= S_RESET_PLL;
      cnt       <= '0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      retry_cnt <= retry_n;
      loss_cnt  <= loss_n;
    end
  end

  // Next-state and counter updates.
  always_comb begin
    state_n = state;
    retry_n = retry_cnt;
    loss_n  = loss_cnt;
    unique case (state)
      S_RESET_PLL: begin
        if (cnt == CNT_W'(PLL_RST_CYCLES - 1)) state_n = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_n = S_STABLE;
        end else if (cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
          retry_n = retry_cnt + RC_W'(1);
          state_n = (retry_n == RC_W'(MAX_RETRIES)) ? S_FAULT : S_RESET_PLL;
        end
      end
      S_STABLE: begin
        // Any dropout inside the window sends us back to wait; the timeout
        // restarts but the attempt is not counted as a failure.
        if (!lock_s) begin
          state_n = S_WAIT_LOCK;
        end else if (cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
          state_n = S_RUN;
          retry_n = '0;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_n = S_RESET_PLL;
          loss_n  = (loss_cnt == 8'hFF) ? loss_cnt : loss_cnt + 8'd1;
        end
      end
      S_FAULT: begin
        if (restart) begin
          state_n = S_RESET_PLL;
          retry_n = '0;
        end
      end
      default: state_n = S_RESET_PLL;
    endcase

    // Counter restarts on every state change and idles in the terminal states,
    // so it never needs to count past the largest bound.
    if (state_n != state)                        cnt_n = '0;
    else if (state == S_RUN || state == S_FAULT) cnt_n = cnt;
    else                                         cnt_n = cnt + CNT_W'(1);
  end

  // Moore output decode from the registered state.
  always_comb begin
    pll_reset  = 1'b0;
    sys_rst    = 1'b1;
    clk_ready  = 1'b0;
    lock_fault = 1'b0;
    state_o    = state;
    unique case (state)
      S_RESET_PLL: pll_reset = 1'b1;
      S_RUN: begin
        sys_rst   = 1'b0;
        clk_ready = 1'b1;
      end
      S_FAULT: begin
        pll_reset  = 1'b1;
        lock_fault = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
